// File: rtl/shift_reg_seq.sv
// Sequencer for a parallel-load, bidirectional serial shift register.
// Accepts a command, loads the word, issues LEN shift pulses paced by a
// clock divider, then returns the final register image as a response.
module shift_reg_seq #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [4:0]       cmd_len,
  input  logic             abort,
  input  logic             rx_bit,
  output logic             tx_bit,
  output logic             tx_bit_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_aborted,
  output logic             reg_load,
  output logic [WIDTH-1:0] reg_pdata,
  output logic             reg_shift_right,
  output logic             reg_shift_left,
  output logic             reg_serial_in,
  input  logic [WIDTH-1:0] reg_qdata,
  input  logic             reg_serial_out
);
  localparam int            DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int            LW      = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_TOP = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] data_q, rsp_q;
  logic             dir_q, aborted_q, done_first_q, tx_vld_q;
  logic [LW-1:0]    len_q, cnt_q, len_eff;
  logic [DW-1:0]    div_q;
  logic             pulse, last_pulse;

  // Effective length: 0 (and anything beyond the register) means a full word.
  always_comb begin
    len_eff = LW'(WIDTH);
    if (cmd_len != '0 && 32'(cmd_len) <= 32'(WIDTH)) len_eff = LW'(cmd_len);
  end

  // A pulse fires when the divider is at its top; abort or reset suppresses it
  // so the register never sees a stray edge while we bail out.
  assign pulse      = (state == SHIFT) && (div_q == DIV_TOP) && !abort && !reset;
  assign last_pulse = pulse && ((cnt_q + LW'(1)) == len_q);

  // Next-state and control outputs.
  always_comb begin
    state_nxt       = state;
    cmd_ready       = 1'b0;
    reg_load        = 1'b0;
    reg_shift_right = 1'b0;
    reg_shift_left  = 1'b0;
    reg_serial_in   = 1'b0;
    rsp_valid       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = LOAD;
      end
      LOAD: begin
        reg_load  = !reset;
        state_nxt = abort ? DONE : SHIFT;
      end
      SHIFT: begin
        reg_shift_right = pulse && !dir_q;
        reg_shift_left  = pulse && dir_q;
        reg_serial_in   = pulse && rx_bit;
        if (abort || last_pulse) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The register's qdata already holds the final image in DONE's first
  // cycle, so pass it through then and serve the captured copy afterwards.
  assign rsp_data     = done_first_q ? reg_qdata : rsp_q;
  assign rsp_aborted  = aborted_q;
  assign reg_pdata    = data_q;
  assign tx_bit       = reg_serial_out;
  assign tx_bit_valid = tx_vld_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Command latch, divider / bit counter, response capture and tx valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q       <= '0;
      dir_q        <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      div_q        <= '0;
      rsp_q        <= '0;
      aborted_q    <= 1'b0;
      done_first_q <= 1'b0;
      tx_vld_q     <= 1'b0;
    end else begin
      tx_vld_q     <= pulse;
      done_first_q <= (state != DONE) && (state_nxt == DONE);
      if (done_first_q) rsp_q <= reg_qdata;
      case (state)
        IDLE: if (cmd_valid) begin
          data_q <= cmd_data;
          dir_q  <= cmd_dir;
          len_q  <= len_eff;
        end
        LOAD: begin
          div_q <= DIV_TOP;
          cnt_q <= '0;
          if (abort) aborted_q <= 1'b1;
        end
        SHIFT: begin
          if (abort) aborted_q <= 1'b1;
          else if (div_q == DIV_TOP) begin
            div_q <= '0;
            cnt_q <= cnt_q + LW'(1);
          end else div_q <= div_q + DW'(1);
        end
        DONE: if (rsp_ready) begin
          aborted_q <= 1'b0;
          div_q     <= '0;
          cnt_q     <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_reg_seq.sv
// Scoreboarded bench for shift_reg_seq with a behavioural shift register
// attached. Expected pulses, tx bits and responses are queued at command
// issue time from the transfer rules; a negedge monitor pops and compares.
module tb_shift_reg_seq;
  localparam int W   = 16;
  localparam int DIV = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main DUT (DIV=4)
  logic         cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0, rx_bit = 1'b0, rsp_ready = 1'b0;
  logic [W-1:0] cmd_data = '0;
  logic [4:0]   cmd_len = '0;
  logic         cmd_ready, tx_bit, tx_bit_valid, rsp_valid, rsp_aborted;
  logic         reg_load, reg_shift_right, reg_shift_left, reg_serial_in, reg_serial_out;
  logic [W-1:0] rsp_data, reg_pdata, reg_qdata;
  logic [W-1:0] q0 = '0;
  logic         so0 = 1'b0;

  // secondary DUT (DIV=1)
  logic         b_valid = 1'b0, b_dir = 1'b0, b_abort = 1'b0, b_rx = 1'b0, b_rready = 1'b1;
  logic [W-1:0] b_data = '0;
  logic [4:0]   b_len = '0;
  logic         b_ready, b_tx, b_txv, b_rv, b_rab, b_load, b_sr, b_sl, b_sin, b_so;
  logic [W-1:0] b_rdata, b_pdata, b_q;
  logic [W-1:0] q1 = '0;
  logic         so1 = 1'b0;

  shift_reg_seq #(.WIDTH(W), .DIV(DIV)) u0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_len(cmd_len), .abort(abort),
    .rx_bit(rx_bit), .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_aborted(rsp_aborted), .reg_load(reg_load), .reg_pdata(reg_pdata),
    .reg_shift_right(reg_shift_right), .reg_shift_left(reg_shift_left),
    .reg_serial_in(reg_serial_in), .reg_qdata(reg_qdata), .reg_serial_out(reg_serial_out));

  shift_reg_seq #(.WIDTH(W), .DIV(1)) u1 (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_data(b_data), .cmd_dir(b_dir), .cmd_len(b_len), .abort(b_abort),
    .rx_bit(b_rx), .tx_bit(b_tx), .tx_bit_valid(b_txv),
    .rsp_valid(b_rv), .rsp_ready(b_rready), .rsp_data(b_rdata),
    .rsp_aborted(b_rab), .reg_load(b_load), .reg_pdata(b_pdata),
    .reg_shift_right(b_sr), .reg_shift_left(b_sl),
    .reg_serial_in(b_sin), .reg_qdata(b_q), .reg_serial_out(b_so));

  // behavioural external registers (serial_out is registered)
  assign reg_qdata = q0;
  assign reg_serial_out = so0;
  always @(posedge clk) begin
    if (reg_load) q0 <= reg_pdata;
    else if (reg_shift_right) begin so0 <= q0[0];   q0 <= {reg_serial_in, q0[W-1:1]}; end
    else if (reg_shift_left)  begin so0 <= q0[W-1]; q0 <= {q0[W-2:0], reg_serial_in}; end
  end
  assign b_q = q1;
  assign b_so = so1;
  always @(posedge clk) begin
    if (b_load) q1 <= b_pdata;
    else if (b_sr) begin so1 <= q1[0];   q1 <= {b_sin, q1[W-1:1]}; end
    else if (b_sl) begin so1 <= q1[W-1]; q1 <= {q1[W-2:0], b_sin}; end
  end

  typedef struct { int cyc; logic dir; logic sin; } pulse_t;
  typedef struct { int cyc; logic b; } tx_t;
  typedef struct { logic [W-1:0] d; logic ab; int rise; } rsp_t;
  pulse_t pq[$];
  tx_t    tq[$];
  rsp_t   rq[$];

  int total = 0, bad = 0, cyc = 0;
  logic rx_tab[1024];
  logic hold = 1'b0;
  logic [W-1:0] cur_d = '0;
  logic cur_dir = 1'b0;
  int cur_t0 = -10, cur_L = 0;

  function automatic void chk_eq(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Register image after n pulses: right shifts push received bits into the
  // top, left shifts into the bottom, the loaded word slides the other way.
  function automatic logic [W-1:0] model_rsp(input logic [W-1:0] d, input logic dir,
                                             input int t0, input int n);
    longint unsigned acc, base, mask;
    mask = (64'd1 << W) - 64'd1;
    acc  = 0;
    for (int k = 0; k < n; k++)
      if (rx_tab[(t0 + 2 + k * DIV) % 1024])
        acc |= dir ? (64'd1 << (n - 1 - k)) : (64'd1 << (W - n + k));
    base = dir ? ((64'(d) << n) & mask) : (64'(d) >> n);
    return W'(acc | base);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    rx_bit    = rx_tab[cyc % 1024];
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  // mode 0: random, 1: all ones
  task automatic fill_rx(input int mode);
    for (int i = 0; i < 1024; i++) rx_tab[i] = (mode == 1) ? 1'b1 : 1'($urandom);
    rx_bit = rx_tab[cyc % 1024];
  endtask

  task automatic issue(input logic [W-1:0] d, input logic dir, input logic [4:0] len);
    int w = 0;
    pulse_t p; tx_t x; rsp_t r;
    cmd_valid = 1'b1; cmd_data = d; cmd_dir = dir; cmd_len = len;
    while (!cmd_ready && w < 500) begin tick(); w++; end
    chk_eq("accept_timeout", cmd_ready, 1);
    if (cmd_ready) begin
      cur_d = d; cur_dir = dir; cur_t0 = cyc;
      cur_L = (len == 0) ? W : int'(len);
      for (int k = 0; k < cur_L; k++) begin
        p.cyc = cur_t0 + 2 + k * DIV; p.dir = dir; p.sin = rx_tab[p.cyc % 1024];
        pq.push_back(p);
        x.cyc = p.cyc + 1; x.b = dir ? d[W-1-k] : d[k];
        tq.push_back(x);
      end
      r.d = model_rsp(d, dir, cur_t0, cur_L); r.ab = 1'b0;
      r.rise = cur_t0 + 3 + (cur_L - 1) * DIV;
      rq.push_back(r);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_abort();
    int a, n, span;
    rsp_t r;
    a = cyc; abort = 1'b1;
    while (pq.size() > 0 && pq[pq.size()-1].cyc >= a) void'(pq.pop_back());
    while (tq.size() > 0 && tq[tq.size()-1].cyc > a) void'(tq.pop_back());
    span = a - (cur_t0 + 2);
    n = (span <= 0) ? 0 : (span + DIV - 1) / DIV;
    if (rq.size() > 0) void'(rq.pop_back());
    r.d = model_rsp(cur_d, cur_dir, cur_t0, n); r.ab = 1'b1; r.rise = a + 1;
    rq.push_back(r);
    tick();
    abort = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((rq.size() != 0 || !cmd_ready) && w < 1000) begin tick(); w++; end
    chk_eq("idle_timeout", w < 1000, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    chk_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    chk_eq({tag, "_rsp_aborted"}, rsp_aborted, 0);
    chk_eq({tag, "_rsp_data"}, rsp_data, 0);
    chk_eq({tag, "_tx_valid"}, tx_bit_valid, 0);
    chk_eq({tag, "_ctrl"}, {reg_load, reg_shift_right, reg_shift_left, reg_serial_in}, 0);
    chk_eq({tag, "_pdata"}, reg_pdata, 0);
  endtask

  // monitor: pulses, tx bits, load, response and cmd_ready while pending
  logic rv_d = 1'b0;
  always @(negedge clk) begin
    pulse_t p; tx_t x; rsp_t r;
    if (reset) rv_d <= 1'b0;
    else begin
      if (reg_shift_right && reg_shift_left) chk_eq("both_shifts", 1, 0);
      if (reg_shift_right || reg_shift_left) begin
        chk_eq("pulse_pending", pq.size() != 0, 1);
        if (pq.size() != 0) begin
          p = pq.pop_front();
          chk_eq("pulse_cycle", cyc, p.cyc);
          chk_eq("pulse_dir", reg_shift_left, p.dir);
          chk_eq("serial_in", reg_serial_in, p.sin);
        end
      end
      if (tx_bit_valid) begin
        chk_eq("tx_pending", tq.size() != 0, 1);
        if (tq.size() != 0) begin
          x = tq.pop_front();
          chk_eq("tx_cycle", cyc, x.cyc);
          chk_eq("tx_bit", tx_bit, x.b);
        end
      end
      if (reg_load) begin
        chk_eq("load_cycle", cyc, cur_t0 + 1);
        chk_eq("load_data", reg_pdata, cur_d);
      end
      if (rsp_valid) chk_eq("cmd_ready_in_done", cmd_ready, 0);
      if (rsp_valid && !rv_d) begin
        chk_eq("rsp_expected", rq.size() != 0, 1);
        if (rq.size() != 0) chk_eq("rsp_latency", cyc, rq[0].rise);
      end
      if (rsp_valid && rsp_ready && rq.size() != 0) begin
        r = rq.pop_front();
        chk_eq("rsp_data", rsp_data, r.d);
        chk_eq("rsp_aborted", rsp_aborted, r.ab);
        chk_eq("pulses_left", pq.size(), 0);
        chk_eq("tx_left", tq.size(), 0);
      end
      rv_d <= rsp_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, np, nl, fp, lp, ntx, rise, a;
    logic [W-1:0] txw, rdat;
    fill_rx(0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk_reset_outs("reset");
    chk_eq("reset_u1_ready", b_ready, 1);

    // DIV=1 instance: 16 back-to-back right shifts of A5C3
    b_valid = 1'b1; b_data = 16'hA5C3; b_dir = 1'b0; b_len = 5'd16;
    t = cyc;
    tick();
    b_valid = 1'b0;
    np = 0; nl = 0; fp = -1; lp = -1; ntx = 0; rise = -1; txw = '0; rdat = '1;
    for (int j = 0; j < 24; j++) begin
      if (b_sr) begin if (fp < 0) fp = cyc; lp = cyc; np++; end
      if (b_sl) nl++;
      if (b_txv) begin if (ntx < W) txw[ntx] = b_tx; ntx++; end
      if (b_rv && rise < 0) begin rise = cyc; rdat = b_rdata; end
      tick();
    end
    chk_eq("div1_pulses", np, 16);
    chk_eq("div1_left", nl, 0);
    chk_eq("div1_first", fp - t, 2);
    chk_eq("div1_last", lp - t, 17);
    chk_eq("div1_ntx", ntx, 16);
    chk_eq("div1_txbits", txw, 16'hA5C3);
    chk_eq("div1_latency", rise - t, 18);
    chk_eq("div1_rsp", rdat, 16'h0000);

    // left shift of 8001, four pulses, rx held high
    fill_rx(1);
    issue(16'h8001, 1'b1, 5'd4);
    wait_idle();
    fill_rx(0);

    // abort two cycles after the first pulse of a full-length transfer
    issue(16'($urandom), 1'b0, 5'd16);
    while (cyc < cur_t0 + 4) tick();
    do_abort();
    wait_idle();

    // response held off while the next command waits
    hold = 1'b1; rsp_ready = 1'b0;
    issue(16'($urandom), 1'b1, 5'd5);
    a = 0;
    while (!rsp_valid && a < 200) begin tick(); a++; end
    chk_eq("hold_rsp_seen", rsp_valid, 1);
    cmd_valid = 1'b1; cmd_data = 16'h1234; cmd_dir = 1'b0; cmd_len = 5'd3;
    for (int j = 0; j < 10; j++) begin
      chk_eq("hold_valid", rsp_valid, 1);
      chk_eq("hold_ready", cmd_ready, 0);
      if (rq.size() != 0) chk_eq("hold_data", rsp_data, rq[0].d);
      tick();
    end
    hold = 1'b0;
    issue(16'h1234, 1'b0, 5'd3);
    wait_idle();

    // reset in the middle of a len=0 transfer
    issue(16'($urandom), 1'($urandom), 5'd0);
    while (cyc < cur_t0 + 2 + 5 * DIV + 1) tick();
    reset = 1'b1;
    pq.delete(); tq.delete(); rq.delete();
    tick();
    reset = 1'b0;
    chk_reset_outs("midreset");
    repeat (4 * W) tick();

    // len=0 runs to completion with a full 16 pulses
    issue(16'($urandom), 1'($urandom), 5'd0);
    wait_idle();

    // randomized transfers, some aborted at a random point
    for (int i = 0; i < 30; i++) begin
      issue(16'($urandom), 1'($urandom), 5'($urandom_range(0, 16)));
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(cur_t0 + 1, cur_t0 + 2 + (cur_L - 1) * DIV);
        while (cyc < a) tick();
        do_abort();
      end
      wait_idle();
    end

    repeat (4) tick();
    chk_eq("end_pulses_left", pq.size(), 0);
    chk_eq("end_tx_left", tq.size(), 0);
    chk_eq("end_rsp_left", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
